// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin sharing of one 18x18 signed multiplier among NUM_REQ requesters.
// Optional WAIT-state abort is built when MULTIPLIER_ARBITER_TIMEOUT_EN is defined.
module multiplier_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [18*NUM_REQ-1:0]   a_flat,
  input  logic [18*NUM_REQ-1:0]   b_flat,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      done,
  output logic [35:0]             p,
  output logic [17:0]             mul_a,
  output logic [17:0]             mul_b,
  output logic                    mul_input_rdy,
  input  logic                    mul_busy,
  input  logic [35:0]             mul_p,
  output logic                    arb_busy,
  output logic                    timeout_err
);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] last_q, last_d, grant_q, grant_d, pick;
  logic [NUM_REQ-1:0] ack_q, ack_d, done_q, done_d;
  logic [35:0] p_q, p_d;
  logic [17:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic rdy_q, rdy_d, found;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
`endif
  function automatic logic [GW-1:0] wrap(int v);
    return GW'(v % NUM_REQ);
  endfunction
  // lowest offset from last_q+1 wins, so scan offsets from the far end down
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[wrap(int'(last_q) + k)]) begin
        pick  = wrap(int'(last_q) + k);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = '0;
    done_d  = '0;
    p_d     = p_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    rdy_d   = 1'b0;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: if (found) begin
        grant_d     = pick;
        mul_a_d     = a_flat[18*int'(pick) +: 18];
        mul_b_d     = b_flat[18*int'(pick) +: 18];
        ack_d[pick] = 1'b1;
        rdy_d       = 1'b1;
        state_d     = ISSUE;
      end
      ISSUE: state_d = GUARD;
      GUARD: state_d = WAIT;
      WAIT: if (!mul_busy) begin
        p_d             = mul_p;
        done_d[grant_q] = 1'b1;
        last_d          = grant_q;
        state_d         = IDLE;
      end
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        p_d             = '0;
        done_d[grant_q] = 1'b1;
        err_d           = 1'b1;
        last_d          = grant_q;
        state_d         = IDLE;
      end else cnt_d = cnt_q + CW'(1);
`endif
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      p_q     <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      rdy_q   <= 1'b0;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      p_q     <= p_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      rdy_q   <= rdy_d;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end
  assign ack           = ack_q;
  assign done          = done_q;
  assign p             = p_q;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign mul_input_rdy = rdy_q;
  assign arb_busy      = state_q != IDLE;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
  assign timeout_err   = err_q;
`else
  assign timeout_err   = 1'b0;
`endif
endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter: scoreboard bench with a behavioural multiplier of programmable busy time.
module tb_multiplier_arbiter;
  logic clk = 1'b0, resetn = 1'b0;
  logic [3:0] req = '0;
  logic [71:0] a_flat = '0, b_flat = '0;
  logic [3:0] ack, done;
  logic [35:0] p, mul_p;
  logic [17:0] mul_a, mul_b;
  logic mul_input_rdy, mul_busy, arb_busy, timeout_err;
  always #5 clk = ~clk;
  multiplier_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .resetn(resetn), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .ack(ack), .done(done), .p(p), .mul_a(mul_a), .mul_b(mul_b),
    .mul_input_rdy(mul_input_rdy), .mul_busy(mul_busy), .mul_p(mul_p),
    .arb_busy(arb_busy), .timeout_err(timeout_err));
  int lat = 3, mcnt = 0;
  logic stuck = 1'b0;
  logic [35:0] mprod = '0;
  always @(posedge clk) begin
    if (mul_input_rdy) begin
      mcnt  <= lat;
      mprod <= $signed(mul_a) * $signed(mul_b);
    end else if (mcnt > 0) mcnt <= mcnt - 1;
  end
  assign mul_busy = stuck || mcnt != 0;
  assign mul_p    = mprod;
  typedef struct {int idx; logic [35:0] p; int c;} ev_t;
  typedef struct {int idx; logic [35:0] p;} exp_t;
  ev_t done_obs[$];
  int ack_obs[$];
  exp_t sb[$];
  int cyc = 0, rdy_cyc = 0, rdy_cnt = 0, overlap = 0, hold_bad = 0;
  int checks = 0, passes = 0;
  logic [17:0] prev_a = '0, prev_b = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if ($countones(ack) > 1 || $countones(done) > 1) overlap++;
    if (arb_busy && !mul_input_rdy && (mul_a != prev_a || mul_b != prev_b)) hold_bad++;
    prev_a = mul_a;
    prev_b = mul_b;
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) ack_obs.push_back(i);
      if (done[i]) done_obs.push_back('{i, p, cyc});
    end
    if (mul_input_rdy) begin
      rdy_cnt++;
      rdy_cyc = cyc;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(int i, longint a, longint b);
    a_flat[18*i +: 18] = 18'(a);
    b_flat[18*i +: 18] = 18'(b);
  endtask
  task automatic push(int i, longint a, longint b);
    exp_t e;
    e.idx = i;
    e.p   = 36'(a * b);
    sb.push_back(e);
  endtask
  task automatic clear_obs();
    ack_obs.delete();
    done_obs.delete();
    rdy_cnt = 0;
  endtask
  task automatic wait_acks(int n, int budget, output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      tick();
      if (ack_obs.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic wait_dones(int n, int budget, output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      tick();
      if (done_obs.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    tick();
    checks++;
    if ({ack, done, p, mul_a, mul_b, mul_input_rdy} !== '0) $display("FAIL reset_outputs: got %h required 0", {ack, done, p, mul_a, mul_b, mul_input_rdy});
    else passes++;
    checks++;
    if ({arb_busy, timeout_err} !== 2'b00) $display("FAIL reset_flags: got %b required 00", {arb_busy, timeout_err});
    else passes++;
    tick();
    resetn = 1'b1;
    tick();
  endtask
  task automatic test_fairness();
    bit ok;
    ev_t d;
    exp_t e;
    clear_obs();
    lat = 1;
    set_op(0, 11, -3); set_op(1, -7, 13); set_op(2, 1000, -1000); set_op(3, -131072, 2);
    push(0, 11, -3); push(1, -7, 13); push(2, 1000, -1000); push(3, -131072, 2); push(0, 11, -3);
    req = 4'b1111;
    wait_acks(5, 80, ok);
    req = 4'b0000;
    wait_dones(5, 40, ok);
    checks++;
    if (!ok) $display("FAIL fair_timeout: got %0d dones required 5", done_obs.size());
    else passes++;
    while (done_obs.size() > 0 && sb.size() > 0) begin
      d = done_obs.pop_front();
      e = sb.pop_front();
      checks++;
      if (d.idx !== e.idx || d.p !== e.p) $display("FAIL fair_job: got idx %0d p %0d required idx %0d p %0d", d.idx, $signed(d.p), e.idx, $signed(e.p));
      else passes++;
    end
    checks++;
    if (overlap !== 0 || hold_bad !== 0) $display("FAIL fair_overlap_hold: got %0d/%0d required 0/0", overlap, hold_bad);
    else passes++;
    sb.delete();
  endtask
  task automatic test_single();
    bit ok;
    ev_t d;
    exp_t e;
    clear_obs();
    lat = 3;
    set_op(0, 300, -200);
    push(0, 300, -200);
    req = 4'b0001;
    wait_acks(1, 10, ok);
    req = 4'b0000;
    wait_dones(1, 20, ok);
    checks++;
    if (!ok) $display("FAIL single_timeout: got no done required one");
    else passes++;
    if (ok) begin
      d = done_obs.pop_front();
      e = sb.pop_front();
      checks++;
      if (d.idx !== 0 || d.p !== e.p || d.p !== 36'hF_FFFF_15A0) $display("FAIL single_job: got idx %0d p %0d required idx 0 p -60000", d.idx, $signed(d.p));
      else passes++;
      checks++;
      if (d.c - rdy_cyc !== 5) $display("FAIL single_latency: got %0d required 5", d.c - rdy_cyc);
      else passes++;
    end
    repeat (6) tick();
    checks++;
    if (rdy_cnt !== 1 || ack_obs.size() !== 1 || done_obs.size() !== 0) $display("FAIL single_pulses: got rdy %0d acks %0d extra dones %0d required 1 1 0", rdy_cnt, ack_obs.size(), done_obs.size());
    else passes++;
    checks++;
    if (arb_busy !== 1'b0) $display("FAIL single_idle: got %b required 0", arb_busy);
    else passes++;
  endtask
  task automatic test_extremes();
    bit ok;
    ev_t d;
    lat = 2;
    for (int j = 0; j < 2; j++) begin
      clear_obs();
      if (j == 0) set_op(0, -131072, -131072);
      else set_op(3, 131071, -131072);
      req = (j == 0) ? 4'b0001 : 4'b1000;
      wait_acks(1, 10, ok);
      req = 4'b0000;
      wait_dones(1, 20, ok);
      checks++;
      if (!ok) $display("FAIL extreme_timeout_%0d: got no done required one", j);
      else begin
        d = done_obs.pop_front();
        if (d.p !== ((j == 0) ? 36'h4_0000_0000 : 36'hC_0002_0000)) $display("FAIL extreme_%0d: got %0d required %0d", j, $signed(d.p), (j == 0) ? 64'sd17179869184 : -64'sd17179738112);
        else passes++;
      end
    end
  endtask
  task automatic test_operand_change();
    bit ok;
    ev_t d;
    exp_t e;
    clear_obs();
    set_op(1, 5, 7);
    push(1, 5, 7);
    req = 4'b0010;
    wait_acks(1, 10, ok);
    set_op(1, 9, 7);
    req = 4'b0000;
    wait_dones(1, 20, ok);
    checks++;
    if (!ok) $display("FAIL opchg_timeout: got no done required one");
    else begin
      d = done_obs.pop_front();
      e = sb.pop_front();
      if (d.idx !== 1 || d.p !== e.p || d.p !== 36'd35) $display("FAIL opchg: got idx %0d p %0d required idx 1 p 35", d.idx, $signed(d.p));
      else passes++;
    end
  endtask
  task automatic test_reset_mid();
    bit ok;
    ev_t d;
    exp_t e;
    clear_obs();
    lat = 20;
    set_op(2, -77, 33);
    req = 4'b0100;
    wait_acks(1, 10, ok);
    req = 4'b0000;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    checks++;
    if ({ack, done, p, mul_a, mul_b, mul_input_rdy, arb_busy, timeout_err} !== '0) $display("FAIL midreset_outputs: got %h required 0", {ack, done, p, mul_a, mul_b, mul_input_rdy, arb_busy, timeout_err});
    else passes++;
    repeat (2) tick();
    resetn = 1'b1;
    repeat (3) tick();
    checks++;
    if (done_obs.size() !== 0) $display("FAIL midreset_nodone: got %0d dones required 0", done_obs.size());
    else passes++;
    clear_obs();
    lat = 2;
    push(2, -77, 33);
    req = 4'b0100;
    wait_acks(1, 10, ok);
    req = 4'b0000;
    wait_dones(1, 20, ok);
    checks++;
    if (!ok) $display("FAIL midreset_retry_timeout: got no done required one");
    else begin
      d = done_obs.pop_front();
      e = sb.pop_front();
      if (d.idx !== 2 || d.p !== e.p) $display("FAIL midreset_retry: got idx %0d p %0d required idx 2 p %0d", d.idx, $signed(d.p), $signed(e.p));
      else passes++;
    end
  endtask
  task automatic test_stuck();
    bit ok;
    ev_t d;
    exp_t e;
    clear_obs();
    stuck = 1'b1;
    set_op(0, 123, 456);
    req = 4'b0001;
    wait_acks(1, 10, ok);
    req = 4'b0000;
`ifdef MULTIPLIER_ARBITER_TIMEOUT_EN
    wait_dones(1, 40, ok);
    checks++;
    if (!ok) $display("FAIL timeout_nodone: got no done required one");
    else begin
      d = done_obs.pop_front();
      if (d.idx !== 0 || d.p !== '0 || d.c - rdy_cyc !== 17) $display("FAIL timeout_done: got idx %0d p %0d delay %0d required 0 0 17", d.idx, $signed(d.p), d.c - rdy_cyc);
      else passes++;
    end
    stuck = 1'b0;
    repeat (3) tick();
    checks++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b required 1", timeout_err);
    else passes++;
    clear_obs();
    lat = 2;
    set_op(1, -5, 6);
    push(1, -5, 6);
    req = 4'b0010;
    wait_acks(1, 10, ok);
    req = 4'b0000;
    wait_dones(1, 20, ok);
    checks++;
    if (!ok) $display("FAIL timeout_next_nodone: got no done required one");
    else begin
      d = done_obs.pop_front();
      e = sb.pop_front();
      if (d.idx !== 1 || d.p !== e.p || timeout_err !== 1'b1) $display("FAIL timeout_next: got idx %0d p %0d err %b required 1 -30 1", d.idx, $signed(d.p), timeout_err);
      else passes++;
    end
`else
    repeat (40) tick();
    checks++;
    if (done_obs.size() !== 0 || arb_busy !== 1'b1 || timeout_err !== 1'b0) $display("FAIL stuck_wait: got dones %0d busy %b err %b required 0 1 0", done_obs.size(), arb_busy, timeout_err);
    else passes++;
    resetn = 1'b0;
    stuck = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    checks++;
    if (arb_busy !== 1'b0) $display("FAIL stuck_recover: got %b required 0", arb_busy);
    else passes++;
`endif
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_extremes();
    test_operand_change();
    test_reset_mid();
    test_stuck();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
